// File: rtl/truth_sweep_pkg.sv
// -----------------------------------------------------------------------------
// truth_sweep_pkg
// Shared types and constants for the truth-table sweeper:
//   state_e  : sweep FSM states (IDLE, DRIVE, CHECK, FINISH)
//   MODE_SOP : term mask lists minterms  (mask bit i set -> F(i) = 1)
//   MODE_POS : term mask lists maxterms  (mask bit i set -> F(i) = 0)
//   SETTLE_W : width of the settle down-counter (SETTLE range 0..15)
// -----------------------------------------------------------------------------
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/tt_ref_eval.sv
// -----------------------------------------------------------------------------
// tt_ref_eval
// Golden reference for an N_IN-input single-output function described by a
// term list. Purely combinational so it can be dropped into other benches.
// Ports:
//   mask    : term list, bit i belongs to input vector i
//   mode    : MODE_SOP (minterms) or MODE_POS (maxterms)
//   vec     : input vector being evaluated
//   ref_out : expected function value for vec
// -----------------------------------------------------------------------------
module tt_ref_eval
    import truth_sweep_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [(1 << N_IN)-1:0] mask,
    input  logic                   mode,
    input  logic [N_IN-1:0]        vec,
    output logic                   ref_out
);

    logic term_s;

    // Look up the term bit and invert it for maxterm lists.
    always_comb begin
        term_s = mask[vec];
        if (mode == MODE_POS) begin
            ref_out = ~term_s;
        end else begin
            ref_out = term_s;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustive checker for an N_IN-input combinational function. Steps vec_out
// through 0..2^N_IN-1, waits SETTLE cycles per vector, then compares dut_out
// with the reference derived from the latched term mask.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : begin a sweep (only honoured in IDLE)
//   mode, term_mask      : term interpretation and list, latched at start
//   hold                 : stall while in DRIVE/CHECK
//   vec_out / dut_out    : vector to the DUT and its response
//   ref_out              : reference value for the current vec_out
//   busy                 : sweep in progress
//   check, mismatch      : compare strobe and failing-compare strobe
//   err_count            : mismatches in the current/last sweep
//   first_err_idx/_vld   : first failing vector
//   done, pass           : end-of-sweep pulse and verdict (held until start)
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = N_IN + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [(1 << N_IN)-1:0] term_mask,
    input  logic                   hold,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   dut_out,
    output logic                   ref_out,
    output logic                   busy,
    output logic                   check,
    output logic                   mismatch,
    output logic [CNT_W-1:0]       err_count,
    output logic [N_IN-1:0]        first_err_idx,
    output logic                   first_err_vld,
    output logic                   done,
    output logic                   pass
);

    localparam int                  NV       = 1 << N_IN;
    localparam logic [N_IN-1:0]     VEC_LAST = N_IN'(NV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    state_e                state_q, state_d;
    logic [N_IN-1:0]       vec_q, vec_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  mode_q, mode_d;
    logic [NV-1:0]         mask_q, mask_d;
    logic [CNT_W-1:0]      err_q, err_d;
    logic [N_IN-1:0]       fidx_q, fidx_d;
    logic                  fvld_q, fvld_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  ref_s;
    logic                  check_s;
    logic                  mismatch_s;

    tt_ref_eval #(.N_IN(N_IN)) u_ref (
        .mask    (mask_q),
        .mode    (mode_q),
        .vec     (vec_q),
        .ref_out (ref_s)
    );

    // Sweep FSM: next-state, datapath updates and compare strobes.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        mode_d     = mode_q;
        mask_d     = mask_q;
        err_d      = err_q;
        fidx_d     = fidx_q;
        fvld_d     = fvld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        check_s    = 1'b0;
        mismatch_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    mask_d   = term_mask;
                    err_d    = {CNT_W{1'b0}};
                    fvld_d   = 1'b0;
                    pass_d   = 1'b0;
                    vec_d    = {N_IN{1'b0}};
                    busy_d   = 1'b1;
                    settle_d = SETTLE_V;
                    state_d  = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                // The CHECK cycle itself is the last settle cycle, so a
                // count of 1 (or 0) hands over to CHECK.
                if (hold) begin
                    state_d = DRIVE;
                end else if (settle_q <= SETTLE_W'(1)) begin
                    settle_d = {SETTLE_W{1'b0}};
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                    state_d  = DRIVE;
                end
            end
            CHECK: begin
                if (hold) begin
                    state_d = CHECK;
                end else begin
                    check_s    = 1'b1;
                    mismatch_s = (dut_out != ref_s);
                    if (mismatch_s) begin
                        err_d = err_q + CNT_W'(1);
                        if (!fvld_q) begin
                            fidx_d = vec_q;
                            fvld_d = 1'b1;
                        end else begin
                            fidx_d = fidx_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = FINISH;
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        settle_d = SETTLE_V;
                        // With no settle time the next vector is compared
                        // straight away, giving back-to-back checks.
                        if (SETTLE_V == SETTLE_W'(0)) begin
                            state_d = CHECK;
                        end else begin
                            state_d = DRIVE;
                        end
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                pass_d  = (err_q == {CNT_W{1'b0}});
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            vec_q    <= {N_IN{1'b0}};
            settle_q <= {SETTLE_W{1'b0}};
            mode_q   <= MODE_SOP;
            mask_q   <= {NV{1'b0}};
            err_q    <= {CNT_W{1'b0}};
            fidx_q   <= {N_IN{1'b0}};
            fvld_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fvld_q   <= fvld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign vec_out       = vec_q;
    assign ref_out       = ref_s;
    assign busy          = busy_q;
    assign check         = check_s;
    assign mismatch      = mismatch_s;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_vld = fvld_q;
    assign done          = done_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed bench: a 4-input/SETTLE=1 sweeper against a table-driven DUT model
// (POS, fault, SOP, stall, reset, ignored start) and a 2-input/SETTLE=0
// sweeper against an AND gate.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] term_mask;
    logic        hold;
    logic [3:0]  vec_out;
    logic        dut_out;
    logic        ref_out;
    logic        busy;
    logic        check;
    logic        mismatch;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        first_err_vld;
    logic        done;
    logic        pass;
    logic [15:0] dut_tt;

    logic        start2;
    logic        mode2;
    logic [3:0]  mask2;
    logic        hold2;
    logic [1:0]  vec2;
    logic        dut2;
    logic        ref2;
    logic        busy2;
    logic        check2;
    logic        mis2;
    logic [2:0]  err2;
    logic [1:0]  fidx2;
    logic        fvld2;
    logic        done2;
    logic        pass2;

    int          checks = 0;
    int          errors = 0;
    int          chk_cnt = 0;
    int          mis_cnt = 0;
    logic [3:0]  mis_vec = 4'd0;

    assign dut_out = dut_tt[vec_out];
    assign dut2    = &vec2;

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u4 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .term_mask(term_mask), .hold(hold), .vec_out(vec_out),
        .dut_out(dut_out), .ref_out(ref_out), .busy(busy), .check(check),
        .mismatch(mismatch), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
        .done(done), .pass(pass)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2),
        .term_mask(mask2), .hold(hold2), .vec_out(vec2),
        .dut_out(dut2), .ref_out(ref2), .busy(busy2), .check(check2),
        .mismatch(mis2), .err_count(err2),
        .first_err_idx(fidx2), .first_err_vld(fvld2),
        .done(done2), .pass(pass2)
    );

    always #5 clk = ~clk;

    // Strobe monitor for u4: counts compares and mismatches per sweep.
    always @(negedge clk) begin
        if (start && !busy) begin
            chk_cnt <= 0;
            mis_cnt <= 0;
        end else if (check) begin
            chk_cnt <= chk_cnt + 1;
            if (mismatch) begin
                mis_cnt <= mis_cnt + 1;
                mis_vec <= vec_out;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one u4 sweep; optional stall at vector hold_at and a stray start
    // pulse at cycle restart_at. Returns cycles from the start edge to done.
    task automatic sweep(input logic m, input logic [15:0] msk, input logic [15:0] tt,
                         input int hold_at, input int restart_at, output int cyc);
        int held_cnt;
        mode      = m;
        term_mask = msk;
        dut_tt    = tt;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        mode      = ~m;
        term_mask = ~msk;
        cyc       = 0;
        held_cnt  = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (held_cnt >= 2 && held_cnt <= 5) begin
                chk("hold_vec_frozen", vec_out, 32'(hold_at));
                chk("hold_no_check", check, 1'b0);
            end
            if (held_cnt == 0 && hold_at >= 0 && vec_out == 4'(hold_at)) begin
                hold     = 1'b1;
                held_cnt = 1;
            end else if (held_cnt >= 1 && held_cnt < 5) begin
                held_cnt++;
            end else if (held_cnt == 5) begin
                hold     = 1'b0;
                held_cnt = 6;
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        int cyc;
        int first_c;
        int last_c;
        int n_chk2;
        int n_mis2;
        clk = 1'b0; reset = 1'b1; start = 1'b0; mode = 1'b0; term_mask = 16'h0000;
        hold = 1'b0; dut_tt = 16'h0000;
        start2 = 1'b0; mode2 = 1'b0; mask2 = 4'h0; hold2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec", vec_out, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", err_count, 5'd0);
        chk("rst_fvld", first_err_vld, 1'b0);
        chk("rst_fidx", first_err_idx, 4'd0);
        chk("rst_check", check, 1'b0);
        chk("rst_ref", ref_out, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // POS reference against matching DUT.
        sweep(1'b1, 16'h4957, 16'hB6A8, -1, -1, cyc);
        chk("pos_cycles", cyc, 33);
        chk("pos_err", err_count, 5'd0);
        chk("pos_pass", pass, 1'b1);
        chk("pos_fvld", first_err_vld, 1'b0);
        chk("pos_nchk", chk_cnt, 16);
        chk("pos_nmis", mis_cnt, 0);
        chk("pos_busy", busy, 1'b0);
        chk("pos_nowrap", vec_out, 4'hF);
        @(posedge clk); #1;
        chk("pos_done_pulse", done, 1'b0);
        chk("pos_pass_held", pass, 1'b1);

        // Single fault on vector 11.
        sweep(1'b1, 16'h4957, 16'hBEA8, -1, -1, cyc);
        chk("flt_err", err_count, 5'd1);
        chk("flt_fidx", first_err_idx, 4'hB);
        chk("flt_fvld", first_err_vld, 1'b1);
        chk("flt_pass", pass, 1'b0);
        chk("flt_nmis", mis_cnt, 1);
        chk("flt_misvec", mis_vec, 4'hB);

        // SOP interpretation of the same mask: every vector mismatches.
        sweep(1'b0, 16'h4957, 16'hB6A8, -1, -1, cyc);
        chk("sop_err", err_count, 5'h10);
        chk("sop_fidx", first_err_idx, 4'h0);
        chk("sop_fvld", first_err_vld, 1'b1);
        chk("sop_pass", pass, 1'b0);
        chk("sop_nmis", mis_cnt, 16);

        // Five-cycle stall while driving vector 6.
        sweep(1'b1, 16'h4957, 16'hB6A8, 6, -1, cyc);
        chk("stall_cycles", cyc, 38);
        chk("stall_err", err_count, 5'd0);
        chk("stall_pass", pass, 1'b1);
        chk("stall_nchk", chk_cnt, 16);

        // Reset in the middle of a failing sweep.
        mode = 1'b0; term_mask = 16'h4957; dut_tt = 16'hB6A8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (vec_out != 4'd5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_reached_v5", vec_out, 4'd5);
        chk("mid_err_before", err_count, 5'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_vec", vec_out, 4'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", err_count, 5'd0);
        chk("mid_rst_fvld", first_err_vld, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst_beats_start", busy, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        // Clean sweep with a stray start pulse while busy.
        sweep(1'b1, 16'h4957, 16'hB6A8, -1, 10, cyc);
        chk("restart_cycles", cyc, 33);
        chk("restart_err", err_count, 5'd0);
        chk("restart_pass", pass, 1'b1);
        chk("restart_nchk", chk_cnt, 16);

        // Two-input AND with no settle time.
        mode2 = 1'b0; mask2 = 4'b1000; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        mask2  = 4'b0000;
        cyc = 0; first_c = -1; last_c = -1; n_chk2 = 0; n_mis2 = 0;
        while (done2 !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (check2) begin
                n_chk2++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            if (mis2) n_mis2++;
        end
        chk("n2_done_seen", done2, 1'b1);
        chk("n2_nchk", n_chk2, 4);
        chk("n2_consecutive", last_c - first_c, 3);
        chk("n2_nmis", n_mis2, 0);
        chk("n2_err", err2, 3'd0);
        chk("n2_pass", pass2, 1'b1);
        chk("n2_fvld", fvld2, 1'b0);
        chk("n2_fidx", fidx2, 2'd0);
        chk("n2_busy", busy2, 1'b0);
        chk("n2_nowrap", vec2, 2'd3);
        chk("n2_ref_last", ref2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule
